// File: rtl/handover_pkg.sv
// Shared types and helpers for the handover controller: FSM state encoding,
// index-width helper and the argmax tie-break rule.
package handover_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TTT  = 2'd1,
        ST_REQ  = 2'd2
    } ho_state_e;

    // On equal signal quality the lowest cell index is kept as the best cell.
    localparam logic TIE_LOWEST_IDX = 1'b1;

    function automatic int idx_w(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/sq_argmax.sv
// Combinational search for the strongest cell among N_CELLS packed
// signal-quality samples; reports its index and its quality value.
module sq_argmax
    import handover_pkg::*;
#(
    parameter int N_CELLS = 3,
    parameter int SQ_W    = 8,
    localparam int IDX_W  = idx_w(N_CELLS)
) (
    input  logic [N_CELLS*SQ_W-1:0] sq,
    output logic [IDX_W-1:0]        best_idx,
    output logic [SQ_W-1:0]         best_sq
);

    // Linear scan; only a strictly larger sample displaces the current best
    // when the lowest-index tie rule is selected.
    always_comb begin
        best_idx = {IDX_W{1'b0}};
        best_sq  = sq[SQ_W-1:0];
        for (int i = 1; i < N_CELLS; i++) begin
            if ((sq[i*SQ_W +: SQ_W] > best_sq) ||
                (!TIE_LOWEST_IDX && (sq[i*SQ_W +: SQ_W] == best_sq))) begin
                best_idx = IDX_W'(i);
                best_sq  = sq[i*SQ_W +: SQ_W];
            end else begin
                best_idx = best_idx;
                best_sq  = best_sq;
            end
        end
    end

endmodule

// File: rtl/handover_ctrl.sv
// Handover controller: registers cell samples, picks the strongest cell and
// requests a handover after hysteresis and time-to-trigger qualification.
module handover_ctrl
    import handover_pkg::*;
#(
    parameter int N_CELLS = 3,
    parameter int SQ_W    = 8,
    parameter int DATA_W  = 4,
    parameter int HYST    = 4,
    parameter int TTT     = 3,
    localparam int IDX_W  = idx_w(N_CELLS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    compare_enable,
    input  logic [N_CELLS*SQ_W-1:0] sq_in,
    input  logic [DATA_W-1:0]       data_in,
    input  logic                    ho_ack,
    output logic                    ho_req,
    output logic [IDX_W-1:0]        ho_target,
    output logic [IDX_W-1:0]        serving,
    output logic                    serving_vld,
    output logic [N_CELLS*SQ_W-1:0] sq_out,
    output logic [DATA_W-1:0]       final_data
);

    localparam int CNT_W = idx_w(TTT + 1);
    localparam logic [SQ_W:0] HYST_EXT = (SQ_W+1)'(HYST);

    logic [N_CELLS*SQ_W-1:0] sq_r;
    logic [DATA_W-1:0]       data_r;
    ho_state_e               state_r;
    ho_state_e               state_nxt_s;
    logic [IDX_W-1:0]        cand_r;
    logic [IDX_W-1:0]        cand_nxt_s;
    logic [CNT_W-1:0]        cnt_r;
    logic [CNT_W-1:0]        cnt_nxt_s;
    logic [CNT_W-1:0]        cnt_inc_s;
    logic                    ho_req_r;
    logic [IDX_W-1:0]        ho_target_r;
    logic [IDX_W-1:0]        serving_r;
    logic                    serving_vld_r;
    logic [IDX_W-1:0]        best_idx_s;
    logic [SQ_W-1:0]         best_sq_s;
    logic [SQ_W-1:0]         serving_sq_s;
    logic                    qualify_s;
    logic                    ack_take_s;

    sq_argmax #(
        .N_CELLS (N_CELLS),
        .SQ_W    (SQ_W)
    ) u_argmax (
        .sq       (sq_r),
        .best_idx (best_idx_s),
        .best_sq  (best_sq_s)
    );

    // Sample and data registers: plain one-cycle copies of the inputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sq_r   <= {(N_CELLS*SQ_W){1'b0}};
            data_r <= {DATA_W{1'b0}};
        end else begin
            sq_r   <= sq_in;
            data_r <= data_in;
        end
    end

    // Qualification is done one bit wider than the samples so serving+HYST
    // cannot wrap near full scale.
    always_comb begin
        serving_sq_s = sq_r[serving_r*SQ_W +: SQ_W];
        if (!serving_vld_r) begin
            qualify_s = 1'b1;
        end else begin
            qualify_s = (best_idx_s != serving_r) &&
                        ({1'b0, best_sq_s} > ({1'b0, serving_sq_s} + HYST_EXT));
        end
    end

    // The handshake only completes once the request is visible on ho_req.
    always_comb begin
        ack_take_s = (state_r == ST_REQ) && ho_req_r && ho_ack;
        cnt_inc_s  = cnt_r + CNT_W'(1);
    end

    // Next-state logic for IDLE / TTT / REQ, candidate latch and TTT counter.
    always_comb begin
        state_nxt_s = state_r;
        cand_nxt_s  = cand_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (compare_enable && qualify_s) begin
                    cand_nxt_s = best_idx_s;
                    if (!serving_vld_r || (TTT == 1)) begin
                        state_nxt_s = ST_REQ;
                        cnt_nxt_s   = {CNT_W{1'b0}};
                    end else begin
                        state_nxt_s = ST_TTT;
                        cnt_nxt_s   = CNT_W'(1);
                    end
                end else begin
                    cnt_nxt_s = {CNT_W{1'b0}};
                end
            end
            ST_TTT: begin
                if (!compare_enable || !qualify_s) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else if (best_idx_s != cand_r) begin
                    cand_nxt_s = best_idx_s;
                    cnt_nxt_s  = CNT_W'(1);
                end else if (cnt_inc_s == CNT_W'(TTT)) begin
                    state_nxt_s = ST_REQ;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_nxt_s = cnt_inc_s;
                end
            end
            ST_REQ: begin
                if (ack_take_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // FSM state, latched candidate and TTT counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cand_r  <= {IDX_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cand_r  <= cand_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Request/serving outputs; ho_target is captured once per request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ho_req_r      <= 1'b0;
            ho_target_r   <= {IDX_W{1'b0}};
            serving_r     <= {IDX_W{1'b0}};
            serving_vld_r <= 1'b0;
        end else begin
            ho_req_r <= (state_r == ST_REQ) && !ack_take_s;
            if ((state_r == ST_REQ) && !ho_req_r) begin
                ho_target_r <= cand_r;
            end else begin
                ho_target_r <= ho_target_r;
            end
            if (ack_take_s) begin
                serving_r     <= ho_target_r;
                serving_vld_r <= 1'b1;
            end else begin
                serving_r     <= serving_r;
                serving_vld_r <= serving_vld_r;
            end
        end
    end

    assign ho_req      = ho_req_r;
    assign ho_target   = ho_target_r;
    assign serving     = serving_r;
    assign serving_vld = serving_vld_r;
    assign sq_out      = sq_r;
    assign final_data  = data_r;

endmodule

// File: tb/tb_handover_ctrl.sv
// Directed bench for handover_ctrl: per-cycle vector table for attach and
// hysteresis/TTT, then hand-written multi-cycle corner sequences.
module tb_handover_ctrl;

    logic        clk;
    logic        reset;
    logic        compare_enable;
    logic [23:0] sq_in;
    logic [3:0]  data_in;
    logic        ho_ack;
    logic        ho_req;
    logic [1:0]  ho_target;
    logic [1:0]  serving;
    logic        serving_vld;
    logic [23:0] sq_out;
    logic [3:0]  final_data;

    int checks = 0;
    int errors = 0;

    handover_ctrl #(
        .N_CELLS (3),
        .SQ_W    (8),
        .DATA_W  (4),
        .HYST    (4),
        .TTT     (3)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .compare_enable (compare_enable),
        .sq_in          (sq_in),
        .data_in        (data_in),
        .ho_ack         (ho_ack),
        .ho_req         (ho_req),
        .ho_target      (ho_target),
        .serving        (serving),
        .serving_vld    (serving_vld),
        .sq_out         (sq_out),
        .final_data     (final_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        ce;
        logic [23:0] sq;
        logic [3:0]  data;
        logic        ack;
        logic        exp_req;
        logic [1:0]  exp_tgt;
        logic [1:0]  exp_srv;
        logic        exp_vld;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic r, input logic ce, input logic [23:0] sq,
                                input logic [3:0] d, input logic ack, input logic req,
                                input logic [1:0] tgt, input logic [1:0] srv, input logic vld);
        vec_t v;
        v.rst_n = r; v.ce = ce; v.sq = sq; v.data = d; v.ack = ack;
        v.exp_req = req; v.exp_tgt = tgt; v.exp_srv = srv; v.exp_vld = vld;
        return v;
    endfunction

    function automatic logic [23:0] pack3(input int c2, input int c1, input int c0);
        return {8'(c2), 8'(c1), 8'(c0)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_outs(input string tag, input logic req, input logic [1:0] tgt,
                            input logic [1:0] srv, input logic vld);
        chk({tag, " ho_req"}, 32'(ho_req), 32'(req));
        chk({tag, " ho_target"}, 32'(ho_target), 32'(tgt));
        chk({tag, " serving"}, 32'(serving), 32'(srv));
        chk({tag, " serving_vld"}, 32'(serving_vld), 32'(vld));
    endtask

    task automatic hold_no_req(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            tick(1);
            chk($sformatf("%s cyc%0d ho_req", tag, k), 32'(ho_req), 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [23:0] s1, s2, s3;
        reset = 1'b0; compare_enable = 1'b0; sq_in = 24'd0; data_in = 4'd0; ho_ack = 1'b0;
        s1 = pack3(20, 50, 10);
        s2 = pack3(20, 50, 54);
        s3 = pack3(20, 50, 55);
        // rst, ce, sq, data, ack | req, tgt, srv, vld (sampled after next edge)
        vecs[0]  = mk(1'b0, 1'b0, 24'd0, 4'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        vecs[1]  = mk(1'b0, 1'b0, 24'd0, 4'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        vecs[2]  = mk(1'b1, 1'b0, s1, 4'hA, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        vecs[3]  = mk(1'b1, 1'b1, s1, 4'hA, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        vecs[4]  = mk(1'b1, 1'b1, s1, 4'hA, 1'b0, 1'b1, 2'd1, 2'd0, 1'b0);
        vecs[5]  = mk(1'b1, 1'b1, s1, 4'hB, 1'b1, 1'b0, 2'd1, 2'd1, 1'b1);
        vecs[6]  = mk(1'b1, 1'b1, s2, 4'h5, 1'b0, 1'b0, 2'd1, 2'd1, 1'b1);
        vecs[7]  = mk(1'b1, 1'b1, s2, 4'h6, 1'b0, 1'b0, 2'd1, 2'd1, 1'b1);
        vecs[8]  = mk(1'b1, 1'b1, s2, 4'h7, 1'b0, 1'b0, 2'd1, 2'd1, 1'b1);
        vecs[9]  = mk(1'b1, 1'b1, s2, 4'h8, 1'b0, 1'b0, 2'd1, 2'd1, 1'b1);
        vecs[10] = mk(1'b1, 1'b1, s3, 4'h3, 1'b0, 1'b0, 2'd1, 2'd1, 1'b1);
        vecs[11] = mk(1'b1, 1'b1, s3, 4'h3, 1'b0, 1'b0, 2'd1, 2'd1, 1'b1);
        vecs[12] = mk(1'b1, 1'b1, s3, 4'h3, 1'b0, 1'b0, 2'd1, 2'd1, 1'b1);
        vecs[13] = mk(1'b1, 1'b1, s3, 4'h3, 1'b0, 1'b0, 2'd1, 2'd1, 1'b1);
        vecs[14] = mk(1'b1, 1'b1, s3, 4'h3, 1'b0, 1'b1, 2'd0, 2'd1, 1'b1);
        vecs[15] = mk(1'b1, 1'b1, s3, 4'h3, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1);
        vecs[16] = mk(1'b1, 1'b1, s3, 4'hC, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1);

        // Reset, initial attach, hysteresis boundary and TTT latency.
        for (int i = 0; i < NV; i++) begin
            reset = vecs[i].rst_n; compare_enable = vecs[i].ce; sq_in = vecs[i].sq;
            data_in = vecs[i].data; ho_ack = vecs[i].ack;
            tick(1);
            chk_outs($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_tgt,
                     vecs[i].exp_srv, vecs[i].exp_vld);
            chk($sformatf("vec%0d sq_out", i), 32'(sq_out), vecs[i].rst_n ? 32'(vecs[i].sq) : 32'd0);
            chk($sformatf("vec%0d final_data", i), 32'(final_data),
                vecs[i].rst_n ? 32'(vecs[i].data) : 32'd0);
        end

        // Serving 0 at 55: cell2 qualifies for only 2 cycles, then drops.
        sq_in = pack3(60, 50, 55);
        tick(2);
        sq_in = pack3(40, 50, 55);
        hold_no_req("ttt_abort", 8);

        // Best moves from cell1 to cell2 mid-count: count restarts on cell2.
        sq_in = pack3(20, 61, 55);
        tick(2);
        sq_in = pack3(70, 61, 55);
        tick(4);
        chk("ttt_restart early ho_req", 32'(ho_req), 32'd0);
        tick(1);
        chk_outs("ttt_restart", 1'b1, 2'd2, 2'd0, 1'b1);
        ho_ack = 1'b1; tick(1); ho_ack = 1'b0;
        chk_outs("ttt_restart ack", 1'b0, 2'd2, 2'd2, 1'b1);

        // Request for cell1 must hold while samples change and evaluation stops.
        sq_in = pack3(70, 80, 61);
        tick(5);
        chk_outs("req_hold enter", 1'b1, 2'd1, 2'd2, 1'b1);
        sq_in = pack3(70, 61, 100); compare_enable = 1'b0;
        tick(3);
        chk_outs("req_hold held", 1'b1, 2'd1, 2'd2, 1'b1);
        ho_ack = 1'b1; tick(1);
        chk_outs("req_hold ack", 1'b0, 2'd1, 2'd1, 1'b1);
        tick(3);
        chk_outs("stray_ack", 1'b0, 2'd1, 2'd1, 1'b1);
        ho_ack = 1'b0;

        // Reset while ho_req is high drops everything without waiting for a clock.
        compare_enable = 1'b1;
        tick(5);
        chk_outs("pre_reset", 1'b1, 2'd0, 2'd1, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk_outs("async_reset", 1'b0, 2'd0, 2'd0, 1'b0);
        chk("async_reset sq_out", 32'(sq_out), 32'd0);
        compare_enable = 1'b0;
        tick(1);

        // Three-way tie with nothing attached: lowest index wins.
        reset = 1'b1; sq_in = pack3(80, 80, 80);
        tick(1);
        compare_enable = 1'b1;
        tick(2);
        chk_outs("tie", 1'b1, 2'd0, 2'd0, 1'b0);
        ho_ack = 1'b1; tick(1); ho_ack = 1'b0;
        chk_outs("tie ack", 1'b0, 2'd0, 2'd0, 1'b1);

        // Near full scale: 252+4 must not wrap, 254 is not above 250+4, 255 is.
        sq_in = pack3(0, 255, 252);
        hold_no_req("no_wrap", 8);
        sq_in = pack3(0, 254, 250);
        hold_no_req("hyst_edge", 8);
        sq_in = pack3(0, 255, 250);
        tick(4);
        chk("hyst_top early ho_req", 32'(ho_req), 32'd0);
        tick(1);
        chk_outs("hyst_top", 1'b1, 2'd1, 2'd0, 1'b1);
        ho_ack = 1'b1; tick(1); ho_ack = 1'b0;
        chk_outs("hyst_top ack", 1'b0, 2'd1, 2'd1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
